// File: rtl/dm_copy_engine.sv
// Block-copy initiator for the 512 x 64-bit data memory. Picks the copy direction
// so overlapping regions copy correctly, and XORs every written word into checksum.
module dm_copy_engine #(
  parameter int DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] src_addr,
  input  logic [11:0] dst_addr,
  input  logic [9:0]  length,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] checksum,
  output logic [11:0] dm_address,
  output logic [63:0] dm_data_write,
  output logic        dm_write_enable,
  input  logic [63:0] dm_data_read
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_n;
  logic [11:0] rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  logic [9:0]  remaining, remaining_n;
  logic        desc, desc_n;
  logic        busy_n, done_n, error_n, we_n;
  logic [63:0] checksum_n, wdata_n;
  logic [11:0] addr_n;

  // 13-bit ends so an out-of-range request can never alias back into the memory
  logic [12:0] src_end, dst_end;
  logic        reject, overlap_fwd;
  logic [11:0] len12;

  assign len12       = {2'b00, length};
  assign src_end     = {1'b0, src_addr} + {3'b000, length};
  assign dst_end     = {1'b0, dst_addr} + {3'b000, length};
  assign reject      = (src_end > 13'(DEPTH)) || (dst_end > 13'(DEPTH));
  assign overlap_fwd = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);

  always_comb begin
    state_n     = state;
    rd_ptr_n    = rd_ptr;
    wr_ptr_n    = wr_ptr;
    remaining_n = remaining;
    desc_n      = desc;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    error_n     = 1'b0;
    we_n        = 1'b0;
    checksum_n  = checksum;
    wdata_n     = dm_data_write;
    addr_n      = 12'd0;
    unique case (state)
      IDLE: begin
        wdata_n = 64'd0;
        if (start) begin
          checksum_n = 64'd0;
          busy_n     = 1'b1;
          if (reject) begin
            state_n = DONE;
            done_n  = 1'b1;
            error_n = 1'b1;
          end else if (length == 10'd0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            desc_n      = overlap_fwd;
            rd_ptr_n    = overlap_fwd ? src_addr + len12 - 12'd1 : src_addr;
            wr_ptr_n    = overlap_fwd ? dst_addr + len12 - 12'd1 : dst_addr;
            remaining_n = length;
            addr_n      = rd_ptr_n;
            state_n     = READ;
          end
        end
      end
      READ: begin
        busy_n  = 1'b1;
        wdata_n = dm_data_read;
        addr_n  = wr_ptr;
        we_n    = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        busy_n      = 1'b1;
        checksum_n  = checksum ^ dm_data_write;
        remaining_n = remaining - 10'd1;
        rd_ptr_n    = desc ? rd_ptr - 12'd1 : rd_ptr + 12'd1;
        wr_ptr_n    = desc ? wr_ptr - 12'd1 : wr_ptr + 12'd1;
        if (remaining == 10'd1) begin
          state_n = DONE;
          done_n  = 1'b1;
          wdata_n = 64'd0;
        end else begin
          addr_n  = rd_ptr_n;
          state_n = READ;
        end
      end
      DONE: begin
        wdata_n = 64'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rd_ptr          <= 12'd0;
      wr_ptr          <= 12'd0;
      remaining       <= 10'd0;
      desc            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      checksum        <= 64'd0;
      dm_address      <= 12'd0;
      dm_data_write   <= 64'd0;
      dm_write_enable <= 1'b0;
    end else begin
      state           <= state_n;
      rd_ptr          <= rd_ptr_n;
      wr_ptr          <= wr_ptr_n;
      remaining       <= remaining_n;
      desc            <= desc_n;
      busy            <= busy_n;
      done            <= done_n;
      // error is only meaningful alongside the done pulse
      error           <= error_n;
      checksum        <= checksum_n;
      dm_address      <= addr_n;
      dm_data_write   <= wdata_n;
      dm_write_enable <= we_n;
    end
  end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Directed bench for dm_copy_engine with a behavioural 512-word memory model.
module tb_dm_copy_engine;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [11:0] src_addr, dst_addr;
  logic [9:0]  length;
  logic        busy, done, error, dm_write_enable;
  logic [63:0] checksum, dm_data_write, dm_data_read;
  logic [11:0] dm_address;

  logic [63:0] mem [512];
  logic        pl_en;
  logic [8:0]  pl_a;
  logic [63:0] pl_d;

  int n_chk = 0, n_pass = 0;
  int n_we, done_j, we_js [32];
  logic [11:0] first_addr;
  logic        err_d, busy_after;
  logic [63:0] cks_d;

  localparam logic [63:0] VA = 64'hA0A0_0000_0000_0001, VB = 64'hB0B0_0000_0000_0020,
                          VC = 64'hC0C0_0000_0000_0300, VD = 64'hD0D0_0000_0000_4000;

  dm_copy_engine dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .error(error), .checksum(checksum),
    .dm_address(dm_address), .dm_data_write(dm_data_write),
    .dm_write_enable(dm_write_enable), .dm_data_read(dm_data_read)
  );

  always #5 clk = ~clk;

  assign dm_data_read = (dm_address < 12'd512) ? mem[dm_address[8:0]] : 64'd0;

  always @(posedge clk) begin
    if (dm_write_enable) mem[dm_address[8:0]] <= dm_data_write;
    else if (pl_en)      mem[pl_a] <= pl_d;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic poke(input int a, input logic [63:0] d);
    pl_en = 1'b1; pl_a = 9'(a); pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Issues one request, then watches cycle j = T+1, T+2, ... until done (bounded).
  task automatic run_op(input logic [11:0] s, input logic [11:0] d, input logic [9:0] l,
                        input bit noisy);
    n_we = 0; done_j = 0; first_addr = '1; err_d = 1'b0; cks_d = '0;
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 2000 && done_j == 0; j++) begin
      if (dm_write_enable) begin
        if (n_we < 32) we_js[n_we] = j;
        if (n_we == 0) first_addr = dm_address;
        n_we++;
      end
      if (done) begin
        done_j = j; err_d = error; cks_d = checksum;
      end
      start = noisy && (j % 2 == 1) && !done;
      if (noisy) begin
        src_addr = 12'($urandom); dst_addr = 12'($urandom); length = 10'($urandom);
      end
      tick();
    end
    start = 1'b0;
    busy_after = busy;
    if (done_j == 0) chk("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0; pl_en = 1'b0;
    pl_a = '0; pl_d = '0;
    for (int i = 0; i < 512; i++) mem[i] = 64'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", error, 0);
    chk("rst_cks", checksum, 0); chk("rst_addr", dm_address, 0);
    chk("rst_wdata", dm_data_write, 0); chk("rst_we", dm_write_enable, 0);

    // basic ascending copy
    poke(0, 64'h11); poke(1, 64'h22); poke(2, 64'h33); poke(3, 64'h44);
    run_op(12'd0, 12'd100, 10'd4, 1'b0);
    chk("basic_nwe", n_we, 4);
    chk("basic_we0", we_js[0], 2); chk("basic_we1", we_js[1], 4);
    chk("basic_we2", we_js[2], 6); chk("basic_we3", we_js[3], 8);
    chk("basic_done", done_j, 9); chk("basic_err", err_d, 0);
    chk("basic_cks", cks_d, 64'h44); chk("basic_busy", busy_after, 0);
    chk("basic_m100", mem[100], 64'h11); chk("basic_m101", mem[101], 64'h22);
    chk("basic_m102", mem[102], 64'h33); chk("basic_m103", mem[103], 64'h44);
    tick();
    chk("cks_hold", checksum, 64'h44); chk("idle_done", done, 0);

    // forward overlap -> descending
    poke(10, VA); poke(11, VB); poke(12, VC); poke(13, VD);
    run_op(12'd10, 12'd12, 10'd4, 1'b0);
    chk("fwd_first", first_addr, 15); chk("fwd_done", done_j, 9);
    chk("fwd_m12", mem[12], VA); chk("fwd_m13", mem[13], VB);
    chk("fwd_m14", mem[14], VC); chk("fwd_m15", mem[15], VD);
    chk("fwd_cks", cks_d, VA ^ VB ^ VC ^ VD);

    // backward overlap -> ascending
    poke(12, VA); poke(13, VB); poke(14, VC); poke(15, VD);
    run_op(12'd12, 12'd10, 10'd4, 1'b0);
    chk("bwd_first", first_addr, 10);
    chk("bwd_m10", mem[10], VA); chk("bwd_m11", mem[11], VB);
    chk("bwd_m12", mem[12], VC); chk("bwd_m13", mem[13], VD);

    // rejects and boundaries
    run_op(12'd500, 12'd0, 10'd20, 1'b0);
    chk("rej_done", done_j, 1); chk("rej_err", err_d, 1);
    chk("rej_nwe", n_we, 0); chk("rej_busy", busy_after, 0); chk("rej_cks", cks_d, 0);
    run_op(12'd0, 12'd509, 10'd4, 1'b0);
    chk("rejdst_err", err_d, 1); chk("rejdst_nwe", n_we, 0);
    run_op(12'd5, 12'd6, 10'd0, 1'b0);
    chk("len0_done", done_j, 1); chk("len0_err", err_d, 0); chk("len0_nwe", n_we, 0);
    poke(508, 64'h5); poke(509, 64'h6); poke(510, 64'h7); poke(511, 64'h8);
    run_op(12'd508, 12'd20, 10'd4, 1'b0);
    chk("edge_err", err_d, 0); chk("edge_nwe", n_we, 4);
    chk("edge_m23", mem[23], 64'h8); chk("edge_cks", cks_d, 64'h5 ^ 64'h6 ^ 64'h7 ^ 64'h8);

    // reset during the third WRITE of a 10-word copy
    for (int i = 0; i < 10; i++) poke(200 + i, 64'h1000 + 64'(i));
    src_addr = 12'd200; dst_addr = 12'd300; length = 10'd10; start = 1'b1;
    tick();
    start = 1'b0; n_we = 0;
    for (int j = 1; j <= 6; j++) begin
      if (dm_write_enable) n_we++;
      if (j == 6) reset = 1'b1;
      tick();
    end
    chk("mrst_we_at6", n_we, 3);
    chk("mrst_busy", busy, 0); chk("mrst_we", dm_write_enable, 0);
    chk("mrst_done", done, 0); chk("mrst_cks", checksum, 0);
    chk("mrst_addr", dm_address, 0); chk("mrst_wdata", dm_data_write, 0);
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (dm_write_enable) n_we++;
      tick();
    end
    chk("mrst_nwe", n_we, 3);
    chk("mrst_m302", mem[302], 64'h1002); chk("mrst_m303", mem[303], 64'h0);
    run_op(12'd200, 12'd310, 10'd2, 1'b0);
    chk("post_done", done_j, 5); chk("post_m311", mem[311], 64'h1001);

    // start pulsed while busy
    for (int i = 0; i < 8; i++) poke(50 + i, 64'hBEEF_0000 + 64'(i));
    run_op(12'd50, 12'd70, 10'd8, 1'b1);
    chk("busy_done", done_j, 17); chk("busy_nwe", n_we, 8);
    chk("busy_m70", mem[70], 64'hBEEF_0000); chk("busy_m77", mem[77], 64'hBEEF_0007);
    chk("busy_after", busy_after, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
